tl_bus_arbiter: RTL

TL_BUS_ARBITER -- requirements
Module: tl_bus_arbiter

---
 rtl/tl_bus_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tl_bus_arbiter.sv
`timescale 1ns/1ps
// Two-master, single-outstanding TileLink-style A/D channel arbiter.
// Round-robin grant, one buffered A beat, D responses routed back by source.
module tl_bus_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_0_valid,
    output logic        io_in_0_ready,
    input  logic [31:0] io_in_0_bits_address,
    input  logic        io_in_1_valid,
    output logic        io_in_1_ready,
    input  logic [2:0]  io_in_1_bits_opcode,
    input  logic [31:0] io_in_1_bits_address,
    input  logic [3:0]  io_in_1_bits_mask,
    input  logic [31:0] io_in_1_bits_data,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [2:0]  io_out_bits_opcode,
    output logic        io_out_bits_source,
    output logic [31:0] io_out_bits_address,
    output logic [3:0]  io_out_bits_mask,
    output logic [31:0] io_out_bits_data,
    input  logic        io_d_valid,
    output logic        io_d_ready,
    input  logic [2:0]  io_d_bits_opcode,
    input  logic        io_d_bits_source,
    input  logic [31:0] io_d_bits_data,
    output logic        io_resp_0_valid,
    input  logic        io_resp_0_ready,
    output logic [31:0] io_resp_0_bits_data,
    output logic        io_resp_1_valid,
    input  logic        io_resp_1_ready,
    output logic [2:0]  io_resp_1_bits_opcode,
    output logic [31:0] io_resp_1_bits_data,
    output logic        io_choseOH_0,
    output logic        io_choseOH_1,
    output logic        io_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_SEND = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] OP_GET = 3'd4;

    state_t      state, state_nxt;
    logic        last, last_nxt;
    logic [1:0]  grant, grant_nxt;
    logic [2:0]  a_opcode, a_opcode_nxt;
    logic        a_source, a_source_nxt;
    logic [31:0] a_address, a_address_nxt;
    logic [3:0]  a_mask, a_mask_nxt;
    logic [31:0] a_data, a_data_nxt;
    logic        err, err_nxt;
    logic        rst_hold;   // high for the first cycle after reset; blocks accepts
    logic        pick_1;

    // State, round-robin pointer, grant, A buffer and sticky error register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            grant     <= '0;
            a_opcode  <= '0;
            a_source  <= 1'b0;
            a_address <= '0;
            a_mask    <= '0;
            a_data    <= '0;
            err       <= 1'b0;
            rst_hold  <= 1'b1;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            grant     <= grant_nxt;
            a_opcode  <= a_opcode_nxt;
            a_source  <= a_source_nxt;
            a_address <= a_address_nxt;
            a_mask    <= a_mask_nxt;
            a_data    <= a_data_nxt;
            err       <= err_nxt;
            rst_hold  <= 1'b0;
        end
    end

    // Next-state, arbitration, handshakes and D-channel routing
    always_comb begin
        state_nxt       = state;
        last_nxt        = last;
        grant_nxt       = grant;
        a_opcode_nxt    = a_opcode;
        a_source_nxt    = a_source;
        a_address_nxt   = a_address;
        a_mask_nxt      = a_mask;
        a_data_nxt      = a_data;
        err_nxt         = err;
        io_in_0_ready   = 1'b0;
        io_in_1_ready   = 1'b0;
        io_out_valid    = 1'b0;
        io_d_ready      = 1'b0;
        io_resp_0_valid = 1'b0;
        io_resp_1_valid = 1'b0;

        // On a tie the port that did not win last time goes next
        if (io_in_0_valid && io_in_1_valid) pick_1 = ~last;
        else                                pick_1 = io_in_1_valid;

        case (state)
            IDLE: begin
                io_d_ready = 1'b1;
                if (io_d_valid) err_nxt = 1'b1;
                if (!rst_hold && (io_in_0_valid || io_in_1_valid)) begin
                    last_nxt  = pick_1;
                    state_nxt = A_SEND;
                    if (pick_1) begin
                        io_in_1_ready = 1'b1;
                        grant_nxt     = 2'b10;
                        a_opcode_nxt  = io_in_1_bits_opcode;
                        a_source_nxt  = 1'b1;
                        a_address_nxt = io_in_1_bits_address;
                        a_mask_nxt    = io_in_1_bits_mask;
                        a_data_nxt    = io_in_1_bits_data;
                    end else begin
                        io_in_0_ready = 1'b1;
                        grant_nxt     = 2'b01;
                        a_opcode_nxt  = OP_GET;
                        a_source_nxt  = 1'b0;
                        a_address_nxt = io_in_0_bits_address;
                        a_mask_nxt    = 4'hF;
                        a_data_nxt    = '0;
                    end
                end
            end
            A_SEND: begin
                io_out_valid = 1'b1;
                io_d_ready   = 1'b1;
                if (io_d_valid) err_nxt = 1'b1;
                if (io_out_ready) state_nxt = D_WAIT;
            end
            D_WAIT: begin
                if (io_d_bits_source == grant[1]) begin
                    io_d_ready      = io_d_bits_source ? io_resp_1_ready : io_resp_0_ready;
                    io_resp_0_valid = io_d_valid & ~io_d_bits_source & grant[0];
                    io_resp_1_valid = io_d_valid &  io_d_bits_source & grant[1];
                    if (io_d_valid && io_d_ready) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else begin
                    // Beat for a master that has nothing outstanding: swallow it
                    io_d_ready = 1'b1;
                    if (io_d_valid) err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // While reset is held the handshakes look like IDLE regardless of state
        if (reset) begin
            io_in_0_ready   = 1'b0;
            io_in_1_ready   = 1'b0;
            io_out_valid    = 1'b0;
            io_resp_0_valid = 1'b0;
            io_resp_1_valid = 1'b0;
            io_d_ready      = 1'b1;
        end
    end

    assign io_out_bits_opcode    = a_opcode;
    assign io_out_bits_source    = a_source;
    assign io_out_bits_address   = a_address;
    assign io_out_bits_mask      = a_mask;
    assign io_out_bits_data      = a_data;
    assign io_resp_0_bits_data   = io_d_bits_data;
    assign io_resp_1_bits_opcode = io_d_bits_opcode;
    assign io_resp_1_bits_data   = io_d_bits_data;
    assign io_choseOH_0          = grant[0];
    assign io_choseOH_1          = grant[1];
    assign io_err                = err;

endmodule
